// File: rtl/serial_addsub_pkg.sv
// Shared definitions for the bit-serial adder/subtractor: FSM encoding and default width.
package serial_addsub_pkg;

  localparam int DEFAULT_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DONE = 2'b10
  } state_t;

endpackage

// File: rtl/serial_addsub_fa_bit.sv
// One-bit full adder cell used by the serial datapath.
module fa_bit (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);

  assign s    = a ^ b ^ cin;
  assign cout = (a & b) | (cin & (a ^ b));

endmodule

// File: rtl/serial_addsub.sv
// Bit-serial adder/subtractor: operands are shifted LSB-first through a single
// full-adder cell, one bit per clock, with the result published on entry to DONE.
module serial_addsub
  import serial_addsub_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             cout,
  output logic             overflow
);

  localparam int             CW   = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0]  LAST = CW'(WIDTH - 1);

  state_t           state;
  state_t           next;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [WIDTH-1:0] acc;
  logic             carry;
  logic [CW-1:0]    cnt;
  logic             s_bit;
  logic             c_bit;

  fa_bit u_fa (
    .a    (a_sh[0]),
    .b    (b_sh[0]),
    .cin  (carry),
    .s    (s_bit),
    .cout (c_bit)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= next;
  end

  always_comb begin
    next = state;
    case (state)
      IDLE:    if (start) next = RUN;
      RUN:     if (cnt == LAST) next = DONE;
      DONE:    next = IDLE;
      default: next = IDLE;
    endcase
  end

  // Subtraction is a + ~b + 1, so the inverted operand and an initial carry of 1
  // are set up at load time. acc needs no clearing: every bit is shifted out by DONE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sh     <= '0;
      b_sh     <= '0;
      acc      <= '0;
      carry    <= 1'b0;
      cnt      <= '0;
      result   <= '0;
      cout     <= 1'b0;
      overflow <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            a_sh  <= a;
            b_sh  <= sub ? ~b : b;
            carry <= sub;
            cnt   <= '0;
          end
        end
        RUN: begin
          a_sh  <= a_sh >> 1;
          b_sh  <= b_sh >> 1;
          acc   <= {s_bit, acc[WIDTH-1:1]};
          carry <= c_bit;
          cnt   <= cnt + CW'(1);
          // On the MSB the carry register holds the carry into the MSB.
          if (cnt == LAST) begin
            result   <= {s_bit, acc[WIDTH-1:1]};
            cout     <= c_bit;
            overflow <= carry ^ c_bit;
          end
        end
        default: ;
      endcase
    end
  end

  assign busy = (state == RUN);
  assign done = (state == DONE);

endmodule

// File: tb/tb_serial_addsub.sv
// Scoreboard bench for serial_addsub: directed 8-bit vectors plus an exhaustive 4-bit sweep.
module tb_serial_addsub;

  typedef struct packed {
    logic [7:0] res;
    logic       co;
    logic       ov;
    int         cyc;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start8, sub8;
  logic [7:0] a8, b8;
  logic       busy8, done8, cout8, ovf8;
  logic [7:0] result8;
  logic       start4, sub4;
  logic [3:0] a4, b4;
  logic       busy4, done4, cout4, ovf4;
  logic [3:0] result4;

  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   doneCount8 = 0;
  int   dc;
  exp_t q8[$];
  exp_t q4[$];
  exp_t got8, got4;

  serial_addsub #(.WIDTH(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .start(start8), .sub(sub8), .a(a8), .b(b8),
    .busy(busy8), .done(done8), .result(result8), .cout(cout8), .overflow(ovf8)
  );

  serial_addsub #(.WIDTH(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .start(start4), .sub(sub4), .a(a4), .b(b4),
    .busy(busy4), .done(done4), .result(result4), .cout(cout4), .overflow(ovf4)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  always @(negedge clk) begin
    if (rst_n && done8) begin
      doneCount8++;
      checks++;
      if (q8.size() == 0) begin
        errors++;
        $display("[TB] FAIL done8_unexpected: result=%h cout=%b ovf=%b, required no done pulse",
                 result8, cout8, ovf8);
      end else begin
        got8 = q8.pop_front();
        if (result8 !== got8.res || cout8 !== got8.co || ovf8 !== got8.ov ||
            busy8 !== 1'b0 || (cyc - got8.cyc) != 8) begin
          errors++;
          $display("[TB] FAIL op8: got result=%h cout=%b ovf=%b busy=%b lat=%0d, required result=%h cout=%b ovf=%b busy=0 lat=8",
                   result8, cout8, ovf8, busy8, cyc - got8.cyc, got8.res, got8.co, got8.ov);
        end
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n && done4) begin
      checks++;
      if (q4.size() == 0) begin
        errors++;
        $display("[TB] FAIL done4_unexpected: result=%h, required no done pulse", result4);
      end else begin
        got4 = q4.pop_front();
        if ({4'h0, result4} !== got4.res || cout4 !== got4.co || ovf4 !== got4.ov ||
            busy4 !== 1'b0 || (cyc - got4.cyc) != 4) begin
          errors++;
          $display("[TB] FAIL op4: got result=%h cout=%b ovf=%b busy=%b lat=%0d, required result=%h cout=%b ovf=%b busy=0 lat=4",
                   result4, cout4, ovf4, busy4, cyc - got4.cyc, got4.res[3:0], got4.co, got4.ov);
        end
      end
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h, required %h", name, act, exp);
    end
  endtask

  task automatic waitIdle8();
    for (int i = 0; i < 100; i++) begin
      if (!busy8 && !done8) return;
      @(negedge clk);
    end
    checks++;
    errors++;
    $display("[TB] FAIL idle8_timeout: busy=%b done=%b, required idle within 100 cycles", busy8, done8);
  endtask

  task automatic waitIdle4();
    for (int i = 0; i < 100; i++) begin
      if (!busy4 && !done4) return;
      @(negedge clk);
    end
    checks++;
    errors++;
    $display("[TB] FAIL idle4_timeout: busy=%b done=%b, required idle within 100 cycles", busy4, done4);
  endtask

  task automatic applyStimulus(input logic s, input logic [7:0] x, input logic [7:0] y,
                               input logic [7:0] er, input logic ec, input logic eo);
    waitIdle8();
    sub8   = s;
    a8     = x;
    b8     = y;
    start8 = 1'b1;
    @(posedge clk);
    #1;
    q8.push_back('{res: er, co: ec, ov: eo, cyc: cyc});
    @(negedge clk);
    start8 = 1'b0;
  endtask

  function automatic exp_t model4(input logic s, input logic [3:0] x, input logic [3:0] y);
    exp_t       e;
    logic [4:0] full;
    logic [3:0] r;
    full = {1'b0, x} + {1'b0, (s ? ~y : y)} + {4'b0, s};
    r    = full[3:0];
    e.res = {4'h0, r};
    e.co  = full[4];
    if (s) e.ov = (x[3] != y[3]) && (r[3] != x[3]);
    else   e.ov = (x[3] == y[3]) && (r[3] != x[3]);
    e.cyc = 0;
    return e;
  endfunction

  task automatic applyStimulus4(input logic s, input logic [3:0] x, input logic [3:0] y);
    exp_t e;
    e = model4(s, x, y);
    waitIdle4();
    sub4   = s;
    a4     = x;
    b4     = y;
    start4 = 1'b1;
    @(posedge clk);
    #1;
    e.cyc = cyc;
    q4.push_back(e);
    @(negedge clk);
    start4 = 1'b0;
  endtask

  initial begin
    rst_n  = 1'b0;
    start8 = 1'b0; sub8 = 1'b0; a8 = '0; b8 = '0;
    start4 = 1'b0; sub4 = 1'b0; a4 = '0; b4 = '0;
    repeat (3) @(negedge clk);
    checkOutput("reset_busy", busy8, 0);
    checkOutput("reset_done", done8, 0);
    checkOutput("reset_result", result8, 0);
    checkOutput("reset_cout", cout8, 0);
    checkOutput("reset_ovf", ovf8, 0);
    rst_n = 1'b1;

    applyStimulus(1'b0, 8'h0F, 8'h01, 8'h10, 1'b0, 1'b0);
    applyStimulus(1'b0, 8'hFF, 8'h01, 8'h00, 1'b1, 1'b0);
    applyStimulus(1'b0, 8'h7F, 8'h01, 8'h80, 1'b0, 1'b1);
    applyStimulus(1'b1, 8'h05, 8'h07, 8'hFE, 1'b0, 1'b0);
    applyStimulus(1'b1, 8'h80, 8'h01, 8'h7F, 1'b1, 1'b1);
    applyStimulus(1'b0, 8'h12, 8'h34, 8'h46, 1'b0, 1'b0);
    applyStimulus(1'b1, 8'h34, 8'h34, 8'h00, 1'b1, 1'b0);

    // Start pulse and operand change in the middle of RUN must be ignored.
    waitIdle8();
    dc = doneCount8;
    applyStimulus(1'b0, 8'h5A, 8'h25, 8'h7F, 1'b0, 1'b0);
    repeat (2) @(negedge clk);
    start8 = 1'b1; sub8 = 1'b1; a8 = 8'hFF; b8 = 8'h0F;
    @(negedge clk);
    start8 = 1'b0;
    waitIdle8();
    repeat (12) @(negedge clk);
    checkOutput("midrun_single_done", doneCount8 - dc, 1);
    checkOutput("midrun_result_held", result8, 8'h7F);

    // Reset during RUN abandons the operation and clears the published outputs.
    applyStimulus(1'b1, 8'h80, 8'h01, 8'h7F, 1'b1, 1'b1);
    waitIdle8();
    checkOutput("pre_reset_cout", cout8, 1);
    applyStimulus(1'b0, 8'h33, 8'h44, 8'h77, 1'b0, 1'b0);
    repeat (3) @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("midrun_reset_busy", busy8, 0);
    checkOutput("midrun_reset_done", done8, 0);
    checkOutput("midrun_reset_result", result8, 0);
    checkOutput("midrun_reset_cout", cout8, 0);
    checkOutput("midrun_reset_ovf", ovf8, 0);
    q8.delete();
    dc = doneCount8;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (12) @(negedge clk);
    checkOutput("reset_no_done", doneCount8 - dc, 0);
    checkOutput("reset_idle_busy", busy8, 0);
    applyStimulus(1'b0, 8'hA5, 8'h5A, 8'hFF, 1'b0, 1'b0);
    waitIdle8();

    for (int s = 0; s < 2; s++)
      for (int x = 0; x < 16; x++)
        for (int y = 0; y < 16; y++)
          applyStimulus4(s[0], x[3:0], y[3:0]);
    waitIdle4();
    repeat (4) @(negedge clk);

    checkOutput("q8_drained", q8.size(), 0);
    checkOutput("q4_drained", q4.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
